dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two, >= 4.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; 4-byte aligned.
REQ-003 SHALL have parameter WAIT_STATES, default 1: extra cycles inserted before each response, range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: request present.
REQ-007 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port req_funct3, input, 3 bits: RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-012 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: load result, sign/zero-extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit: request faulted; no memory side effect.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, registering we, addr, wdata and funct3.
REQ-018 SHALL move IDLE->WAIT on accept when WAIT_STATES>0, and IDLE->RESP when WAIT_STATES=0.
REQ-019 SHALL hold WAIT for exactly WAIT_STATES cycles using a down-counter, then enter RESP; rsp_valid therefore rises WAIT_STATES+1 cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until a rising edge with rsp_ready=1, then return to IDLE; no new accept occurs on that edge.
REQ-021 SHALL compute off = addr - BASE_ADDR and word index = off[log2(DEPTH_WORDS)+1:2]; off >= 4*DEPTH_WORDS is out-of-range.
REQ-022 SHALL flag an error on: out-of-range; H/HU with off[0]!=0; W with off[1:0]!=0; funct3 011, 110 or 111; a store with funct3 100 or 101.
REQ-023 SHALL perform a non-faulting store on the edge entering RESP with byte enables: SB lane off[1:0]; SH lanes {off[1],0} and {off[1],1}; SW all lanes. Other bytes are unchanged.
REQ-024 SHALL sample load data on the edge entering RESP: LB/LBU select byte off[1:0]; LH/LHU select half off[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-025 SHALL suppress the write on any error and return rsp_rdata=0, rsp_err=1.
REQ-026 SHALL give a load issued after a store's response to the same address the newly stored data.
REQ-027 SHALL ignore req_* inputs outside the accept edge; a request held across RESP is accepted in the following IDLE cycle.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0, independent of clk.
REQ-029 SHALL abandon a request in WAIT on reset with no write; a store already committed on entry to RESP stays committed.
REQ-030 SHALL NOT initialise the memory array on reset; its contents persist across rst_n.

Verification
REQ-031 SHALL cover: WAIT_STATES=2; SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-032 SHALL cover: after REQ-031, SB 0x7F @0x11 and LB @0x11 -> 0x0000007F; SB 0x80 @0x12 then LB @0x12 -> 0xFFFFFF80, LBU @0x12 -> 0x00000080; LW @0x10 -> 0xDE807FEF.
REQ-033 SHALL cover: LH @0x13, SW @0x12, and LW @4*DEPTH_WORDS -> err=1, rdata=0; a following LW @0x10 returns the word unchanged.
REQ-034 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; accept happens in the cycle after rsp_ready=1.
REQ-035 SHALL cover: rst_n pulsed low mid-WAIT of SW 0x12345678 @0x20 -> rsp_valid=0 immediately, IDLE afterwards, and LW @0x20 returns the prior content.
REQ-036 SHALL cover: WAIT_STATES=0 with back-to-back requests, req_valid held 1 and rsp_ready held 1 -> one accept every 2 cycles, each response 1 cycle after its accept.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request port, RV32I byte/half/word loads and stores,
// a fixed number of wait states before each response, and alignment/range fault detection.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, commit;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rword;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   load_val;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so decode the live inputs.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we     = req_we;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_funct3 = req_funct3;
    end else begin
      cur_we     = r_we;
      cur_addr   = r_addr;
      cur_wdata  = r_wdata;
      cur_funct3 = r_funct3;
    end
  end

  always_comb begin
    off = cur_addr - BASE_ADDR;
    idx = off[AW+1:2];
    err = (off >= MEM_BYTES);
    case (cur_funct3)
      3'b000:  ;
      3'b100:  err = err | cur_we;
      3'b001:  err = err | off[0];
      3'b101:  err = err | off[0] | cur_we;
      3'b010:  err = err | (|off[1:0]);
      default: err = 1'b1;
    endcase

    be    = '0;
    wlane = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        be[off[1:0]] = 1'b1;
        wlane        = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase

    rword    = mem[idx];
    bsel     = rword[{off[1:0], 3'b000} +: 8];
    hsel     = off[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (cur_funct3)
      3'b000:  load_val = {{24{bsel[7]}}, bsel};
      3'b100:  load_val = {24'd0, bsel};
      3'b001:  load_val = {{16{hsel[15]}}, hsel};
      3'b101:  load_val = {16'd0, hsel};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end
      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_we) ? '0 : load_val;
      end
    end
  end

  // Memory is never reset; rst_n only blocks a zero-wait commit attempted while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with two wait states at base 0 and one
// with zero wait states at base 0x1000, both checked against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned NB = 4 * DW;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_funct3[2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  int unsigned rdy_mode [2] = '{1, 1};  // 0 random, 1 always ready, 2 never ready
  exp_t        exp_q [2][$];
  exp_t        cur [2];
  bit          open [2] = '{0, 0};
  logic [7:0]  mem_m [2][NB];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_ctrl #(
      .DEPTH_WORDS(DW),
      .BASE_ADDR  ((g == 0) ? 32'h0000_0000 : 32'h0000_1000),
      .WAIT_STATES((g == 0) ? 2 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_funct3(req_funct3[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  function automatic int unsigned ws_of(input int unsigned i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] base_of(input int unsigned i);
    return (i == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, req, $time);
  endtask

  // Reference: little-endian byte array, access size from funct3, extension by funct3[2].
  function automatic void model(input int unsigned i, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] rd, output logic err);
    logic [31:0] off;
    int unsigned sz;
    off = a - base_of(i);
    rd  = '0;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    err = (sz == 0) || (off >= NB) || (we && f3[2]);
    if (!err && (off % sz) != 0) err = 1'b1;
    if (err) return;
    for (int unsigned b = 0; b < sz; b++) begin
      if (we) mem_m[i][off + b] = wd[8*b +: 8];
      else    rd[8*b +: 8] = mem_m[i][off + b];
    end
    if (!we && !f3[2] && sz < 4 && rd[8*sz - 1]) rd = rd | (32'hFFFF_FFFF << (8 * sz));
  endfunction

  task automatic do_req(input int unsigned i, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input bit keep,
                        output int unsigned acc);
    exp_t e;
    int unsigned n = 0;
    acc = 0;
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; req_funct3[i] = f3;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      chk("req_ready_timeout", 32'(req_ready[i]), 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    model(i, we, a, wd, f3, e.rd, e.err);
    e.acc = acc;
    exp_q[i].push_back(e);
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic rand_req(input int unsigned i, input bit keep, output int unsigned acc);
    logic [31:0] off;
    off = 32'($urandom_range(0, NB + 7));
    if ($urandom_range(0, 3) != 0) off = off & ~32'd3;
    do_req(i, 1'($urandom_range(0, 2) == 0), base_of(i) + off, $urandom,
           3'($urandom_range(0, 7)), keep, acc);
  endtask

  task automatic drain(input int unsigned i);
    int unsigned n = 0;
    while ((exp_q[i].size() != 0 || open[i]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q[i].size()), 32'd0);
  endtask

  initial begin
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int unsigned i = 0; i < 2; i++)
        rsp_ready[i] = (rdy_mode[i] == 1) ? 1'b1 :
                       (rdy_mode[i] == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per response and checks it on every cycle it is held.
  initial begin
    forever begin
      @(negedge clk);
      for (int unsigned i = 0; i < 2; i++) begin
        if (rsp_valid[i]) begin
          if (!open[i]) begin
            if (exp_q[i].size() == 0) begin
              chk("unexpected_rsp", 32'(exp_q[i].size()), 32'd1);
            end else begin
              cur[i]  = exp_q[i].pop_front();
              open[i] = 1'b1;
              chk("rsp_latency", cyc + 1 - cur[i].acc, ws_of(i) + 1);
            end
          end
          if (open[i]) begin
            chk("rsp_rdata", rsp_rdata[i], cur[i].rd);
            chk("rsp_err", 32'(rsp_err[i]), 32'(cur[i].err));
            chk("req_ready_in_resp", 32'(req_ready[i]), 32'd0);
          end
          if (rsp_ready[i]) open[i] = 1'b0;
        end else begin
          open[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int unsigned acc, prev, c, n;
    for (int unsigned i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   req_funct3[i] = '0;
    end
    #1;
    for (int unsigned i = 0; i < 2; i++) begin
      chk("reset_req_ready", 32'(req_ready[i]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[i], 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Instance 0: fill memory, then the directed sequences, then random traffic.
    rdy_mode[0] = 0;
    for (int unsigned w = 0; w < DW; w++) do_req(0, 1'b1, 32'(4 * w), $urandom, 3'b010, 0, acc);
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, acc);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, acc);
    do_req(0, 1'b1, 32'h11, 32'h0000_007F, 3'b000, 0, acc);
    do_req(0, 1'b0, 32'h11, 32'h0, 3'b000, 0, acc);
    do_req(0, 1'b1, 32'h12, 32'h0000_0080, 3'b000, 0, acc);
    do_req(0, 1'b0, 32'h12, 32'h0, 3'b000, 0, acc);
    do_req(0, 1'b0, 32'h12, 32'h0, 3'b100, 0, acc);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, acc);
    do_req(0, 1'b0, 32'h13, 32'h0, 3'b001, 0, acc);
    do_req(0, 1'b1, 32'h12, 32'hCAFE_F00D, 3'b010, 0, acc);
    do_req(0, 1'b0, 32'(NB), 32'h0, 3'b010, 0, acc);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, acc);
    drain(0);

    // Backpressure: response held five cycles, next request waiting across RESP.
    rdy_mode[0] = 2;
    @(posedge clk);
    #3;
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, acc);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid[0]), 32'd1);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h14; req_funct3[0] = 3'b010;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    end
    rdy_mode[0] = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_ready[0] && n < 10);
    c = cyc;
    do_req(0, 1'b0, 32'h14, 32'h0, 3'b010, 0, acc);
    chk("bp_accept_cycle", acc, c + 2);
    drain(0);

    // Reset mid-WAIT abandons the store.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h1234_5678; req_funct3[0] = 3'b010;
    chk("rst_pre_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 3'b010, 0, acc);

    rdy_mode[0] = 0;
    for (int unsigned k = 0; k < 150; k++) rand_req(0, 0, acc);
    drain(0);

    // Instance 1: zero wait states, back-to-back with req_valid and rsp_ready held high.
    for (int unsigned w = 0; w < DW; w++)
      do_req(1, 1'b1, base_of(1) + 32'(4 * w), $urandom, 3'b010, 0, acc);
    drain(1);
    rdy_mode[1] = 1;
    @(posedge clk);
    #3;
    prev = 0;
    for (int unsigned k = 0; k < 24; k++) begin
      rand_req(1, k != 23, acc);
      if (k > 0) chk("b2b_accept_spacing", acc - prev, 32'd2);
      prev = acc;
    end
    drain(1);
    rdy_mode[1] = 0;
    for (int unsigned k = 0; k < 100; k++) rand_req(1, 0, acc);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
